// File: rtl/xi_bus_capture_if.sv
// XI host parallel port bundle: raw host pins in, registered XI record out.
// master = host/pin side, slave = capture block side.
interface xi_bus_capture_if #(
   parameter int XA_BITS       = 3,
   parameter int XSUBA_MAX     = 7,
   parameter int I2C_TYPE_BITS = 1
);
   logic                      x_wrn;
   logic                      x_rdn;
   logic [XA_BITS-1:0]        x_addr;
   logic [7:0]                x_data;

   logic                      p_wr;
   logic [2**XA_BITS-1:0]     p_rwa;
   logic                      p_rd_active;
   logic                      p_rd_finished;
   logic [XSUBA_MAX:0]        p_rd_suba;
   logic [7-I2C_TYPE_BITS:0]  p_d;
   logic [I2C_TYPE_BITS-1:0]  p_d_type;
   logic                      p_bus_err;

   modport master (
      output x_wrn, x_rdn, x_addr, x_data,
      input  p_wr, p_rwa, p_rd_active, p_rd_finished, p_rd_suba, p_d, p_d_type, p_bus_err
   );

   modport slave (
      input  x_wrn, x_rdn, x_addr, x_data,
      output p_wr, p_rwa, p_rd_active, p_rd_finished, p_rd_suba, p_d, p_d_type, p_bus_err
   );
endinterface

// File: rtl/xi_bus_capture.sv
// XI host port capture: synchronises host strobes/address/data into clk and
// turns strobe activity into the registered XI record signals.
// Optional macro XI_GLITCH_FILTER_EN: strobe lows shorter than MIN_LOW
// synchronised cycles are discarded.
//
// state | meaning
// BOOT  | after reset; waits for sync pipeline to fill and both strobes high
// IDLE  | waiting for a falling strobe
// WRITE | write strobe low; holding address/data
// READ  | read strobe low; p_rd_active high
// ERROR | both strobes seen low together; waits for both high
module xi_bus_capture #(
   parameter int XA_BITS       = 3,
   parameter int XSUBA_MAX     = 7,
   parameter int I2C_TYPE_BITS = 1,
   parameter int SYNC_STAGES   = 2,
   parameter int MIN_LOW       = 2
) (
   input  logic            clk,
   input  logic            rst,
   xi_bus_capture_if.slave bus
);
   localparam int NA     = 2**XA_BITS;
   localparam int BOOT_W = $clog2(SYNC_STAGES+1);

   typedef enum logic [2:0] {BOOT, IDLE, WRITE, READ, ERROR} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] wrn_sync, rdn_sync;
   logic [XA_BITS-1:0]     addr_sync [SYNC_STAGES];
   logic [7:0]             data_sync [SYNC_STAGES];
   logic                   wrn_s, rdn_s, wrn_e, rdn_e, wrn_p, rdn_p;
   logic [XA_BITS-1:0]     addr_s;
   logic [7:0]             data_s;
   logic                   wr_fall, rd_fall;
   logic [BOOT_W-1:0]      boot_cnt;

   logic                   hold_ld, wr_done, rd_entry, rd_done, err_set;
   logic [XA_BITS-1:0]     hold_addr, last_rd_addr;
   logic [7:0]             hold_data;

   logic                   p_wr_q, p_rd_active_q, p_rd_finished_q, p_bus_err_q;
   logic [NA-1:0]          p_rwa_q;
   logic [XSUBA_MAX:0]     p_rd_suba_q;
   logic [7-I2C_TYPE_BITS:0] p_d_q;
   logic [I2C_TYPE_BITS-1:0] p_d_type_q;

   // synchroniser chains; strobes idle high, address/data idle zero
   always_ff @(posedge clk) begin
      if (rst) begin
         wrn_sync <= '1;
         rdn_sync <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= '0;
            data_sync[i] <= '0;
         end
      end else begin
         wrn_sync     <= {wrn_sync[SYNC_STAGES-2:0], bus.x_wrn};
         rdn_sync     <= {rdn_sync[SYNC_STAGES-2:0], bus.x_rdn};
         addr_sync[0] <= bus.x_addr;
         data_sync[0] <= bus.x_data;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= addr_sync[i-1];
            data_sync[i] <= data_sync[i-1];
         end
      end
   end

   assign wrn_s  = wrn_sync[SYNC_STAGES-1];
   assign rdn_s  = rdn_sync[SYNC_STAGES-1];
   assign addr_s = addr_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

`ifdef XI_GLITCH_FILTER_EN
   localparam int CNT_W = (MIN_LOW < 2) ? 1 : $clog2(MIN_LOW+1);
   localparam logic [CNT_W-1:0] LO_SAT = CNT_W'(MIN_LOW-1);
   logic [CNT_W-1:0] wr_lo_cnt, rd_lo_cnt;

   // saturating count of consecutive low samples; a high sample releases at once
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_lo_cnt <= '0;
         rd_lo_cnt <= '0;
      end else begin
         wr_lo_cnt <= wrn_s ? '0 : ((wr_lo_cnt == LO_SAT) ? wr_lo_cnt : wr_lo_cnt + 1'b1);
         rd_lo_cnt <= rdn_s ? '0 : ((rd_lo_cnt == LO_SAT) ? rd_lo_cnt : rd_lo_cnt + 1'b1);
      end
   end

   assign wrn_e = wrn_s | (wr_lo_cnt != LO_SAT);
   assign rdn_e = rdn_s | (rd_lo_cnt != LO_SAT);
`else
   assign wrn_e = wrn_s;
   assign rdn_e = rdn_s;
`endif

   // previous-cycle strobes for edge detection, plus boot timer that lets the
   // sync pipeline fill with real pin values before BOOT may exit
   always_ff @(posedge clk) begin
      if (rst) begin
         wrn_p    <= 1'b1;
         rdn_p    <= 1'b1;
         boot_cnt <= BOOT_W'(SYNC_STAGES);
      end else begin
         wrn_p <= wrn_e;
         rdn_p <= rdn_e;
         if (boot_cnt != '0) boot_cnt <= boot_cnt - 1'b1;
      end
   end

   assign wr_fall = wrn_p & ~wrn_e;
   assign rd_fall = rdn_p & ~rdn_e;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   // next-state and transaction events
   always_comb begin
      state_nxt = state;
      hold_ld   = 1'b0;
      wr_done   = 1'b0;
      rd_entry  = 1'b0;
      rd_done   = 1'b0;
      err_set   = 1'b0;
      case (state)
         BOOT: if (boot_cnt == '0 && wrn_e && rdn_e) state_nxt = IDLE;
         IDLE: begin
            if (!wrn_e && !rdn_e && (wr_fall || rd_fall)) begin
               state_nxt = ERROR;
               err_set   = 1'b1;
            end else if (wr_fall) begin
               state_nxt = WRITE;
               hold_ld   = 1'b1;
            end else if (rd_fall) begin
               state_nxt = READ;
               rd_entry  = 1'b1;
            end
         end
         WRITE: begin
            if (!wrn_e) hold_ld = 1'b1;
            else begin
               state_nxt = IDLE;
               wr_done   = 1'b1;
            end
         end
         READ: begin
            if (rdn_e) begin
               state_nxt = IDLE;
               rd_done   = 1'b1;
            end
         end
         ERROR: if (wrn_e && rdn_e) state_nxt = IDLE;
         default: state_nxt = BOOT;
      endcase
   end

   // registered XI record outputs and holding registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_addr       <= '0;
         hold_data       <= '0;
         last_rd_addr    <= '0;
         p_wr_q          <= 1'b0;
         p_rwa_q         <= '0;
         p_rd_active_q   <= 1'b0;
         p_rd_finished_q <= 1'b0;
         p_rd_suba_q     <= '0;
         p_d_q           <= '0;
         p_d_type_q      <= '0;
         p_bus_err_q     <= 1'b0;
      end else begin
         p_wr_q          <= wr_done;
         p_rd_finished_q <= rd_done;
         if (hold_ld) begin
            hold_addr <= addr_s;
            hold_data <= data_s;
         end
         if (err_set) p_bus_err_q <= 1'b1;
         if (wr_done) begin
            p_rwa_q    <= NA'(1) << hold_addr;
            p_d_q      <= hold_data[7:I2C_TYPE_BITS];
            p_d_type_q <= hold_data[I2C_TYPE_BITS-1:0];
         end
         if (rd_entry) begin
            p_rwa_q       <= NA'(1) << addr_s;
            p_rd_active_q <= 1'b1;
            last_rd_addr  <= addr_s;
         end
         if (rd_done) p_rd_active_q <= 1'b0;
         // the increment lands the cycle after the finish pulse so consumers
         // see the sub-address that was just read
         if (wr_done || (rd_entry && addr_s != last_rd_addr))
            p_rd_suba_q <= '0;
         else if (p_rd_finished_q)
            p_rd_suba_q <= p_rd_suba_q + 1'b1;
      end
   end

   assign bus.p_wr          = p_wr_q;
   assign bus.p_rwa         = p_rwa_q;
   assign bus.p_rd_active   = p_rd_active_q;
   assign bus.p_rd_finished = p_rd_finished_q;
   assign bus.p_rd_suba     = p_rd_suba_q;
   assign bus.p_d           = p_d_q;
   assign bus.p_d_type      = p_d_type_q;
   assign bus.p_bus_err     = p_bus_err_q;
endmodule
